// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the multiplexed seven-segment scan decoder.
// Holds the active-low segment patterns for hex digits 0..F, the number of
// scanned digits, the nibble width, and the synchroniser state type.
package seg_scan_decoder_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;

  // Active-low patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  // HUNT: any digit index may start a frame. TRACK: next index must follow
  // the previously accepted one.
  typedef enum logic {
    SYNC_HUNT,
    SYNC_TRACK
  } sync_state_e;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bundle of the scanned display lines and the decoded frame outputs.
//   seg, sel          : captured display drive (active-low segments, one-hot select)
//   data_out          : last complete frame, digit i in bits [4i+3:4i]
//   frame_valid       : one-cycle pulse when data_out loads
//   digit_mask        : digits accepted in the current partial frame
//   err_seg/err_order : one-cycle error pulses
//   scan_lost         : level, no digit accepted for the timeout period
// master drives the display lines; slave is the decoder.
interface seg_scan_decoder_if;
  import seg_scan_decoder_pkg::*;

  logic [SEG_W-1:0]            seg;
  logic [NUM_DIGITS-1:0]       sel;
  logic [NUM_DIGITS*NIB_W-1:0] data_out;
  logic                        frame_valid;
  logic [NUM_DIGITS-1:0]       digit_mask;
  logic                        err_seg;
  logic                        err_order;
  logic                        scan_lost;

  modport master (
    output seg, sel,
    input  data_out, frame_valid, digit_mask, err_seg, err_order, scan_lost
  );

  modport slave (
    input  seg, sel,
    output data_out, frame_valid, digit_mask, err_seg, err_order, scan_lost
  );
endinterface

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Combinational decode of an active-low seven-segment pattern to a hex nibble.
//   pattern : 7-bit segment pattern (bit 0 = a)
//   nibble  : decoded value, 0 when the pattern is not recognised
//   valid   : high when pattern is one of the 16 hex glyphs
module seg7_to_hex
  import seg_scan_decoder_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [NIB_W-1:0] nibble,
  output logic             valid
);

  always_comb begin
    nibble = '0;
    valid  = 1'b1;
    case (pattern)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers six hex digits from a multiplexed seven-segment display scan.
// Inputs are registered once, each one-hot select must hold an identical
// pattern for STABLE_CYC registered samples before the digit is accepted,
// and six in-order digits form a frame that loads data_out atomically.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of seg_scan_decoder_if (seg/sel in, frame/status out)
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_decoder_if.slave  bus
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] RUN_ACCEPT = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] RUN_SAT    = CNT_W'(STABLE_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT_CYC);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);

  logic [SEG_W-1:0]      seg_q, seg_prev_q;
  logic [NUM_DIGITS-1:0] sel_q, sel_prev_q;
  logic [CNT_W-1:0]      run_q, run_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [2:0]            last_q, last_d;
  logic [NUM_DIGITS-1:0][NIB_W-1:0] nib_q, nib_d;
  logic [NUM_DIGITS*NIB_W-1:0]      data_q, data_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic                  fv_q, fv_d;
  logic                  eseg_q, eseg_d;
  logic                  eord_q, eord_d;
  logic                  lost_q, lost_d;
  sync_state_e           state_q, state_d;

  logic             sel_one_hot;
  logic             accept;
  logic [2:0]       idx;
  logic [2:0]       exp_idx;
  logic [NIB_W-1:0] dec_nib;
  logic             dec_valid;

  seg7_to_hex u_dec (
    .pattern (seg_q),
    .nibble  (dec_nib),
    .valid   (dec_valid)
  );

  assign sel_one_hot = $onehot(sel_q);

  // Run length of the current registered sample. It saturates one above the
  // accept threshold so a long hold matches RUN_ACCEPT exactly once.
  always_comb begin
    run_d = '0;
    if (sel_one_hot) begin
      if (seg_q == seg_prev_q && sel_q == sel_prev_q && run_q != '0) begin
        run_d = (run_q == RUN_SAT) ? run_q : run_q + CNT_W'(1);
      end else begin
        run_d = CNT_W'(1);
      end
    end
  end

  assign accept = sel_one_hot && (run_d == RUN_ACCEPT);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q[i]) idx = 3'(i);
    end
  end

  assign exp_idx = (last_q == LAST_IDX) ? '0 : last_q + 3'd1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    nib_d   = nib_q;
    data_d  = data_q;
    mask_d  = mask_q;
    tmo_d   = tmo_q;
    lost_d  = lost_q;
    fv_d    = 1'b0;
    eseg_d  = 1'b0;
    eord_d  = 1'b0;

    if (accept) begin
      tmo_d  = '0;
      lost_d = 1'b0;
      if (!dec_valid) begin
        eseg_d  = 1'b1;
        mask_d  = '0;
        state_d = SYNC_HUNT;
      end else begin
        nib_d[idx] = dec_nib;
        last_d     = idx;
        state_d    = SYNC_TRACK;
        if (state_q == SYNC_TRACK && idx != exp_idx) begin
          eord_d = 1'b1;
          mask_d = sel_q;
        end else begin
          mask_d = mask_q | sel_q;
          // Load from nib_d so the sixth nibble lands in the same frame.
          if (mask_d == '1) begin
            data_d  = nib_d;
            fv_d    = 1'b1;
            mask_d  = '0;
            state_d = SYNC_HUNT;
          end
        end
      end
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (tmo_d == TMO_MAX) begin
        lost_d  = 1'b1;
        mask_d  = '0;
        state_d = SYNC_HUNT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SYNC_HUNT;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= '0;
      sel_q      <= '0;
      seg_prev_q <= '0;
      sel_prev_q <= '0;
      run_q      <= '0;
      tmo_q      <= '0;
      last_q     <= '0;
      nib_q      <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      fv_q       <= 1'b0;
      eseg_q     <= 1'b0;
      eord_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      seg_q      <= bus.seg;
      sel_q      <= bus.sel;
      seg_prev_q <= seg_q;
      sel_prev_q <= sel_q;
      run_q      <= run_d;
      tmo_q      <= tmo_d;
      last_q     <= last_d;
      nib_q      <= nib_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      fv_q       <= fv_d;
      eseg_q     <= eseg_d;
      eord_q     <= eord_d;
      lost_q     <= lost_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.frame_valid = fv_q;
  assign bus.digit_mask  = mask_q;
  assign bus.err_seg     = eseg_q;
  assign bus.err_order   = eord_q;
  assign bus.scan_lost   = lost_q;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4: consecutive identical registered samples required before a digit is accepted; legal range 2..255.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65536: cycles without an accepted digit before scan_lost asserts.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 seg  input  7  active-low segment lines; seg[0]=a … seg[6]=g.
REQ-007 sel  input  6  active-high one-hot digit select; sel[i] selects display digit i.
REQ-008 data_out  output  24  last complete frame; digit i in bits [4i+3:4i].
REQ-009 frame_valid  output  1  one-cycle pulse when data_out updates.
REQ-010 digit_mask  output  6  digits accepted in the current, incomplete frame.
REQ-011 err_seg  output  1  one-cycle pulse: undecodable segment pattern on a valid select.
REQ-012 err_order  output  1  one-cycle pulse: accepted digit out of scan order.
REQ-013 scan_lost  output  1  level; high while no digit has been accepted for TIMEOUT_CYC cycles.

Function
REQ-014 seg and sel SHALL be registered once; all later logic uses the registered pair.
REQ-015 A registered pair SHALL be a candidate only if sel has exactly one bit set; zero or multiple bits reset the stability count and are otherwise ignored.
REQ-016 Stability counter SHALL increment while the registered pair equals the previous one, and reset to 1 on any change.
REQ-017 The digit SHALL be accepted exactly once per hold: on the cycle the counter reaches STABLE_CYC; a longer hold SHALL NOT re-accept.
REQ-018 Decode table (seg hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
REQ-019 An accepted pair with a pattern not in the table SHALL pulse err_seg the next cycle, leave the digit unstored, and clear digit_mask.
REQ-020 Scan order SHALL be sel[0]->sel[1]->…->sel[5]->sel[0]; expected index = last accepted index + 1 mod 6, with any index allowed after reset, frame completion, err_seg or timeout.
REQ-021 An out-of-order accepted digit SHALL pulse err_order, set digit_mask to that digit's bit only, and store its nibble as a new frame start.
REQ-022 An in-order accepted digit SHALL store its nibble and set its digit_mask bit.
REQ-023 When digit_mask would become 6'h3F, data_out SHALL load all six stored nibbles atomically, frame_valid SHALL pulse the same cycle as the load, and digit_mask SHALL clear.
REQ-024 Latency from the first seg/sel edge of the sixth stable digit to frame_valid SHALL be STABLE_CYC+1 cycles.
REQ-025 The timeout counter SHALL reset on every accepted digit and saturate; at TIMEOUT_CYC, scan_lost sets and digit_mask clears; the next accepted digit clears scan_lost.
REQ-026 err_seg and err_order SHALL never pulse in the same cycle; err_seg takes priority.

Reset
REQ-027 While rst is high, data_out=0, frame_valid=0, digit_mask=0, err_seg=0, err_order=0, scan_lost=0, and the input registers, counters, stored nibbles and expected index SHALL be cleared.
REQ-028 Reset mid-frame SHALL discard partial digits; the first digit after release may be any index.

Structure
REQ-029 The shared package SHALL hold the 16 segment pattern constants, the digit count (6), and the nibble width (4).
REQ-030 The pattern decode SHALL be one combinational sub-module, seg7_to_hex, with 7-bit pattern in and 4-bit nibble plus valid flag out.

Verification
REQ-031 Scan 1,2,3,4,5,6 on sel[0..5] with 8-cycle holds -> one frame_valid, data_out=24'h654321, no errors.
REQ-032 Hold sel[2] for 3 cycles only (STABLE_CYC=4) -> digit not accepted, digit_mask bit 2 stays 0.
REQ-033 seg=7'h7F on sel[1] held for 8 cycles -> err_seg pulse, digit_mask=0.
REQ-034 Accept sel[0], then sel[3] -> err_order pulse, digit_mask=6'b001000.
REQ-035 No stable input for TIMEOUT_CYC cycles -> scan_lost=1; next accepted digit -> scan_lost=0.
REQ-036 Assert rst after 4 digits -> all outputs 0; full rescan -> frame_valid with new data only.
